// File: rtl/adder_sub_ctrl.sv
// rtl/adder_sub_ctrl.sv - command/response sequencer around an external adder_sub datapath.
// One operation in flight; carry chains across ADC/SBB via a stored carry flag.
module adder_sub_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             add_en,
  output logic             sub_en,
  output logic             carry_in,
  input  logic [WIDTH-1:0] data_out,
  input  logic             carry_out,
  input  logic             out_en,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             add_en_q, add_en_d, sub_en_q, sub_en_d;
  logic             carry_in_q, carry_in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_err_q, rsp_err_d;
  logic             carry_flag_q, carry_flag_d;
  logic [15:0]      op_count_q, op_count_d;
  logic [TW-1:0]    timer_q, timer_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      add_en_q     <= 1'b0;
      sub_en_q     <= 1'b0;
      carry_in_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      carry_flag_q <= 1'b0;
      op_count_q   <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      a_q          <= a_d;
      b_q          <= b_d;
      add_en_q     <= add_en_d;
      sub_en_q     <= sub_en_d;
      carry_in_q   <= carry_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
      carry_flag_q <= carry_flag_d;
      op_count_q   <= op_count_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = 1'b0;
    a_d          = a_q;
    b_d          = b_q;
    add_en_d     = add_en_q;
    sub_en_d     = sub_en_q;
    carry_in_d   = carry_in_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    carry_flag_d = carry_flag_q;
    op_count_d   = op_count_q;
    timer_d      = timer_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        // Datapath controls are registered at acceptance so they are live during ISSUE.
        if (cmd_valid && cmd_ready_q) begin
          state_d     = S_ISSUE;
          cmd_ready_d = 1'b0;
          a_d         = cmd_a;
          b_d         = cmd_b;
          add_en_d    = ~cmd_op[0];
          sub_en_d    = cmd_op[0];
          carry_in_d  = cmd_op[1] & carry_flag_q;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (out_en) begin
          rsp_data_d   = data_out;
          rsp_carry_d  = carry_out;
          carry_flag_d = carry_out;
          rsp_err_d    = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          rsp_valid_d  = 1'b1;
          add_en_d     = 1'b0;
          sub_en_d     = 1'b0;
          carry_in_d   = 1'b0;
          state_d      = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d   = '0;
          rsp_carry_d  = 1'b0;
          carry_flag_d = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          add_en_d     = 1'b0;
          sub_en_d     = 1'b0;
          carry_in_d   = 1'b0;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign A         = a_q;
  assign B         = b_q;
  assign add_en    = add_en_q;
  assign sub_en    = sub_en_q;
  assign carry_in  = carry_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_sub_ctrl.sv
// tb/tb_adder_sub_ctrl.sv - controller paired with a behavioural adder_sub, checked against a transaction model.
module tb_adder_sub_ctrl;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
  logic [WIDTH-1:0] a_bus, b_bus;
  logic             add_en, sub_en, carry_in;
  logic [WIDTH-1:0] data_out;
  logic             carry_out, out_en;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry, rsp_err;
  logic [15:0]      op_count;

  adder_sub_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A(a_bus), .B(b_bus), .add_en(add_en), .sub_en(sub_en), .carry_in(carry_in),
    .data_out(data_out), .carry_out(carry_out), .out_en(out_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural adder_sub: result valid out_lat cycles after the enables rise (ISSUE is cycle 0).
  int          en_cnt;
  int          out_lat = 1;
  logic        stray = 1'b0;
  logic [8:0]  add_r;
  assign add_r     = add_en ? ({1'b0, a_bus} + {1'b0, b_bus} + 9'(carry_in))
                            : ({1'b0, a_bus} - {1'b0, b_bus} - 9'(carry_in));
  assign data_out  = add_r[7:0];
  assign carry_out = add_r[8];
  assign out_en    = stray | ((add_en | sub_en) && (en_cnt == out_lat));

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) en_cnt <= 0;
    else          en_cnt <= (add_en | sub_en) ? en_cnt + 1 : 0;
  end

  // Model state: expected registered outputs after the next rising edge.
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_valid, exp_add, exp_sub, exp_cin, exp_carry, exp_err;
  logic [7:0]  exp_a, exp_b, exp_data;
  logic        mcf = 1'b0;
  logic [15:0] mcount = '0;
  logic [7:0]  cap_data;
  logic        cap_carry, cap_err, cap_cin;
  int          n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("cmd_ready", cmd_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      check("add_en", add_en, exp_add);
      check("sub_en", sub_en, exp_sub);
      check("carry_in", carry_in, exp_cin);
      check("op_count", op_count, mcount);
      if (exp_add | exp_sub) begin
        check("A", a_bus, exp_a);
        check("B", b_bus, exp_b);
        cap_cin = carry_in;
      end
      if (exp_valid) begin
        check("rsp_data", rsp_data, exp_data);
        check("rsp_carry", rsp_carry, exp_carry);
        check("rsp_err", rsp_err, exp_err);
      end
      if (rsp_valid) begin
        cap_data  = rsp_data;
        cap_carry = rsp_carry;
        cap_err   = rsp_err;
      end
    end
  end

  task automatic set_idle_expect();
    exp_ready = 1'b1; exp_valid = 1'b0; exp_add = 1'b0; exp_sub = 1'b0; exp_cin = 1'b0;
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_A"}, a_bus, 0);
    check({tag, "_B"}, b_bus, 0);
    check({tag, "_enables"}, {add_en, sub_en, carry_in}, 0);
    check({tag, "_rsp_fields"}, {rsp_data, rsp_carry, rsp_err}, 0);
    check({tag, "_op_count"}, op_count, 0);
  endtask

  // One command end to end; rst_at>0 pulses reset_n in that WAIT cycle and abandons the op.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int lat, input int hold, input int rst_at);
    logic       cin;
    logic [8:0] r;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = 1'b0; stray = 1'b0; out_lat = lat;
    cin = op[1] & mcf;
    exp_ready = 1'b0; exp_a = a; exp_b = b;
    exp_add = ~op[0]; exp_sub = op[0]; exp_cin = cin; exp_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 reset_values("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        set_idle_expect();
        mcf = 1'b0; mcount = '0;
        chk_en = 1'b1;
        return;
      end
      if (k == lat || k == TIMEOUT) begin
        if (k == lat) begin
          r = op[0] ? ({1'b0, a} - {1'b0, b} - 9'(cin)) : ({1'b0, a} + {1'b0, b} + 9'(cin));
          exp_data = r[7:0]; exp_carry = r[8]; exp_err = 1'b0;
          mcf = r[8]; mcount = mcount + 16'd1;
        end else begin
          exp_data = 8'd0; exp_carry = 1'b0; exp_err = 1'b1; mcf = 1'b0;
        end
        exp_valid = 1'b1; exp_add = 1'b0; exp_sub = 1'b0; exp_cin = 1'b0;
        break;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      if (h < hold) begin
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_a = 8'hAA; stray = 1'b1;
      end else begin
        rsp_ready = 1'b1; cmd_valid = 1'b0; stray = (hold > 0);
        exp_valid = 1'b0; exp_ready = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #3 reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;
    set_idle_expect();
    chk_en = 1'b1;

    do_op(2'b00, 8'd10, 8'd20, 1, 0, 0);
    check("add10_20_data", cap_data, 30);
    check("add10_20_carry", cap_carry, 0);
    check("add10_20_err", cap_err, 0);
    check("add10_20_count", op_count, 1);

    do_op(2'b00, 8'd255, 8'd255, 1, 0, 0);
    check("add255_255_data", cap_data, 254);
    check("add255_255_carry", cap_carry, 1);

    do_op(2'b10, 8'd0, 8'd0, 2, 0, 0);
    check("adc0_0_cin", cap_cin, 1);
    check("adc0_0_data", cap_data, 1);
    check("adc0_0_carry", cap_carry, 0);

    do_op(2'b01, 8'd5, 8'd7, 3, 2, 0);
    check("sub5_7_data", cap_data, 254);
    check("sub5_7_borrow", cap_carry, 1);

    do_op(2'b11, 8'd10, 8'd3, 1, 0, 0);
    check("sbb10_3_cin", cap_cin, 1);
    check("sbb10_3_data", cap_data, 6);

    do_op(2'b00, 8'd255, 8'd1, 1, 0, 0);
    check("add255_1_carry", cap_carry, 1);

    do_op(2'b00, 8'd1, 8'd1, 99, 0, 0);
    check("timeout_err", cap_err, 1);
    check("timeout_data", cap_data, 0);
    check("timeout_count", op_count, 6);

    do_op(2'b10, 8'd3, 8'd4, TIMEOUT, 0, 0);
    check("adc_after_timeout_cin", cap_cin, 0);
    check("last_cycle_success_err", cap_err, 0);
    check("last_cycle_success_data", cap_data, 7);

    do_op(2'b01, 8'd1, 8'd1, 0, 0, 0);
    check("out_en_in_issue_err", cap_err, 1);

    do_op(2'b00, 8'd100, 8'd50, 1, 5, 0);
    check("held_rsp_data", cap_data, 150);
    check("held_rsp_count", op_count, 8);

    do_op(2'b00, 8'd1, 8'd2, 99, 0, 3);
    do_op(2'b00, 8'd7, 8'd8, 1, 0, 0);
    check("after_reset_data", cap_data, 15);
    check("after_reset_count", op_count, 1);

    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    mcount = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    do_op(2'b00, 8'd1, 8'd0, 1, 0, 0);
    check("op_count_wrap", op_count, 0);

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
